// File: rtl/layer_output_collector_if.sv
// Neuron-result bus between the last layer and the output collector.
// The slave side is the collector; the master side drives neuron results.
interface layer_output_collector_if #(
  parameter int NUM_NEURON = 10,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_NEURON*DATA_WIDTH-1:0] i_neuron_data;
  logic [NUM_NEURON-1:0]            i_neuron_valid;
  logic                             i_clear;
  logic                             o_ready;
  logic [NUM_NEURON*DATA_WIDTH-1:0] o_data;
  logic                             o_data_valid;
  logic                             o_overrun;

  modport slave (
    input  i_neuron_data,
    input  i_neuron_valid,
    input  i_clear,
    output o_ready,
    output o_data,
    output o_data_valid,
    output o_overrun
  );

  modport master (
    output i_neuron_data,
    output i_neuron_valid,
    output i_clear,
    input  o_ready,
    input  o_data,
    input  o_data_valid,
    input  o_overrun
  );
endinterface

// File: rtl/layer_output_collector.sv
// Collects per-neuron results into one packed vector for the argmax stage,
// emits a one-cycle valid, then blocks input while argmax finishes its scan.
module layer_output_collector #(
  parameter int NUM_NEURON  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int HOLD_CYCLES = NUM_NEURON + 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  layer_output_collector_if.slave bus
);
  localparam int W  = NUM_NEURON * DATA_WIDTH;
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EMIT    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_NEURON-1:0] got_q, got_d;
  logic [W-1:0]          buf_q, buf_d;
  logic [W-1:0]          data_q, data_d;
  logic                  ovr_q, ovr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    buf_d   = buf_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    if (bus.i_clear) begin
      got_d   = '0;
      cnt_d   = '0;
      state_d = S_COLLECT;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          for (int k = 0; k < NUM_NEURON; k++) begin
            if (bus.i_neuron_valid[k]) begin
              if (got_q[k]) begin
                ovr_d = 1'b1;
              end else begin
                buf_d[k*DATA_WIDTH +: DATA_WIDTH] =
                  bus.i_neuron_data[k*DATA_WIDTH +: DATA_WIDTH];
                got_d[k] = 1'b1;
              end
            end
          end
          // Same-edge captures count toward completion
          if (&got_d) begin
            data_d  = buf_d;
            got_d   = '0;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          if (|bus.i_neuron_valid) ovr_d = 1'b1;
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (|bus.i_neuron_valid) ovr_d = 1'b1;
          if (cnt_q == '0) state_d = S_COLLECT;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = S_COLLECT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_COLLECT;
      got_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_ready      = (state_q == S_COLLECT);
  assign bus.o_data_valid = (state_q == S_EMIT);
  assign bus.o_data       = data_q;
  assign bus.o_overrun    = ovr_q;
endmodule
